// File: rtl/riscv_pkg.sv
// Shared RV64I front-end definitions: fetch FSM states, reset PC, canonical NOP
// and base opcodes used by fetch, decode and the immediate generator.
// Latency: n/a (declarations only). Backpressure: n/a.
package riscv_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } ifu_state_e;

  // RV64I base opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b001_1011;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_OP32     = 7'b011_1011;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

endpackage

// File: rtl/ifu_out_reg.sv
// Fetch output holding register: one instruction word plus its PC towards decode.
// Latency: 1 cycle from load_i to valid_o. Backpressure: contents held while
// valid_o && !ready_i; flush_i drops the entry and beats a same-cycle load.
// Ports: clk, rst (sync, active-high); flush_i, load_i, inst_i, pc_i in;
//        valid_o, inst_o, pc_o out with ready_i as the consumer handshake.
module ifu_out_reg
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [31:0]           inst_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  valid_q, valid_d;
  logic [31:0]           inst_q, inst_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      // a reload in the consuming cycle keeps valid high
      valid_d = 1'b1;
      inst_d  = inst_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= INST_NOP;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// RV64I fetch stage: holds the PC, issues one imem request at a time, hands
// word+PC to decode. Latency: response -> inst_valid_o in 1 cycle.
// Backpressure: no request is issued unless the output register is free.
// Ports: clk, rst (sync, active-high); imem_req_{valid_o,ready_i,addr_o};
//        imem_resp_{valid_i,data_i}; redirect_{valid_i,pc_i};
//        inst_{valid_o,ready_i}, inst_o, pc_o; misalign_o.
// Build option: IFU_MISALIGN_TRAP_EN makes a misaligned redirect enter FAULT
// (misalign_o sticky) instead of silently clearing target[1:0].
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_resp_valid_i,
  input  logic [31:0]           imem_resp_data_i,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [31:0]           inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  misalign_o
);

  ifu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;

  logic                  out_free;
  logic                  req_fire;
  logic                  outstanding;
  logic                  out_load;
  logic                  out_flush;
  logic                  tgt_misaligned;
  logic [DATA_WIDTH-1:0] redirect_tgt;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign redirect_tgt   = redirect_pc_i;
  assign tgt_misaligned = |redirect_pc_i[1:0];
  assign misalign_d     = (state_d == FAULT);
  assign misalign_o     = misalign_q;
`else
  logic unused_tgt_lo;

  assign redirect_tgt   = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign tgt_misaligned = 1'b0;
  assign unused_tgt_lo  = ^redirect_pc_i[1:0];
  assign misalign_o     = 1'b0;
`endif

  assign out_free = !inst_valid_o || inst_ready_i;
  assign req_fire = imem_req_valid_o && imem_req_ready_i;

  // A response is still owed by memory if we are waiting without one arriving
  // now, or a request is being accepted this very cycle. FAULT can inherit an
  // abandoned request from a misaligned redirect.
  assign outstanding = ((state_q == WAIT)  && !imem_resp_valid_i) ||
                       ((state_q == FAULT) && drop_q && !imem_resp_valid_i) ||
                       req_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect_valid_i) begin
      pc_d   = redirect_tgt;
      // the flag is rewritten from scratch: a same-cycle response retires
      // any earlier abandoned request, so only a still-owed one is marked
      drop_d = outstanding;
      if (tgt_misaligned) begin
        state_d = FAULT;
      end else if (outstanding) begin
        state_d = WAIT;
      end else begin
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (req_fire) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid_i) begin
            state_d = REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = pc_q + DATA_WIDTH'(4);
            end
          end
        end
        FAULT: begin
          if (imem_resp_valid_i) begin
            drop_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_req_valid_o = (state_q == REQ) && out_free;
    imem_req_addr_o  = pc_q;
    out_flush        = redirect_valid_i;
    // the output register is always free here: requests only issue when free
    out_load         = (state_q == WAIT) && imem_resp_valid_i && !drop_q &&
                       !redirect_valid_i;
  end

  ifu_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (out_flush),
    .load_i  (out_load),
    .inst_i  (imem_resp_data_i),
    .pc_i    (pc_q),
    .ready_i (inst_ready_i),
    .valid_o (inst_valid_o),
    .inst_o  (inst_o),
    .pc_o    (pc_o)
  );

endmodule
